// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and sizing helpers for the matrix loader
package matrix_pkg;

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, FILLED} loader_state_t;

  localparam int DEFAULT_DIM   = 8;
  localparam int DEFAULT_DEPTH = DEFAULT_DIM * DEFAULT_DIM;
  localparam int DEFAULT_WIDTH = 32;

  function automatic int elem_count(input int rows, input int cols);
    return rows * cols;
  endfunction

  // Keeps single-entry dimensions at a legal 1-bit width.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/matrix_addr_counter.sv
// rtl/matrix_addr_counter.sv - row-major position tracker for one matrix memory
module matrix_addr_counter
  import matrix_pkg::*;
#(
  parameter int  ROWS    = DEFAULT_DIM,
  parameter int  COLUMNS = DEFAULT_DIM,
  parameter int  DEPTH   = DEFAULT_DEPTH,
  localparam int AW      = addr_width(DEPTH),
  localparam int RW      = addr_width(ROWS),
  localparam int CW      = addr_width(COLUMNS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  output logic [AW-1:0] address,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last_col,
  output logic          last_elem
);

  localparam int ELEMS = elem_count(ROWS, COLUMNS);

  assign last_col  = (col == CW'(COLUMNS - 1));
  assign last_elem = (address == AW'(ELEMS - 1));

  // Wrapping on the final element keeps the address inside the matrix footprint.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      address <= '0;
      row     <= '0;
      col     <= '0;
    end else if (inc) begin
      if (last_elem) begin
        address <= '0;
        row     <= '0;
        col     <= '0;
      end else begin
        address <= address + 1'b1;
        if (last_col) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - streams A then B elements into their memories, flags completion
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int  MATRIX_A_MEM_DEPTH = DEFAULT_DEPTH,
  parameter int  MATRIX_A_ROWS      = DEFAULT_DIM,
  parameter int  MATRIX_A_COLUMNS   = DEFAULT_DIM,
  parameter int  MATRIX_B_MEM_DEPTH = DEFAULT_DEPTH,
  parameter int  MATRIX_B_ROWS      = DEFAULT_DIM,
  parameter int  MATRIX_B_COLUMNS   = DEFAULT_DIM,
  parameter int  MATRIX_MEM_WIDTH   = DEFAULT_WIDTH,
  localparam int AW_A               = addr_width(MATRIX_A_MEM_DEPTH),
  localparam int AW_B               = addr_width(MATRIX_B_MEM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [MATRIX_MEM_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic                        wr_en_a,
  output logic [AW_A-1:0]             wr_address_a,
  output logic [MATRIX_MEM_WIDTH-1:0] wr_data_a,
  output logic                        wr_en_b,
  output logic [AW_B-1:0]             wr_address_b,
  output logic [MATRIX_MEM_WIDTH-1:0] wr_data_b,
  output logic                        new_row_a,
  output logic                        new_row_b,
  output logic                        memory_filled,
  output logic                        load_error
);

  localparam int RW_A = addr_width(MATRIX_A_ROWS);
  localparam int CW_A = addr_width(MATRIX_A_COLUMNS);
  localparam int RW_B = addr_width(MATRIX_B_ROWS);
  localparam int CW_B = addr_width(MATRIX_B_COLUMNS);

  loader_state_t state, state_next;

  logic            accept, honour_start, inc_a, inc_b, final_b;
  logic [AW_A-1:0] addr_a;
  logic [AW_B-1:0] addr_b;
  logic [RW_A-1:0] row_a;
  logic [CW_A-1:0] col_a;
  logic [RW_B-1:0] row_b;
  logic [CW_B-1:0] col_b;
  logic            last_col_a, last_elem_a, last_col_b, last_elem_b;

  assign in_ready     = (state == LOAD_A) || (state == LOAD_B);
  assign accept       = in_valid && in_ready;
  assign honour_start = start && ((state == IDLE) || (state == FILLED));
  assign inc_a        = accept && (state == LOAD_A);
  assign inc_b        = accept && (state == LOAD_B);
  assign final_b      = (state == LOAD_B) && last_elem_b;

  matrix_addr_counter #(
    .ROWS(MATRIX_A_ROWS), .COLUMNS(MATRIX_A_COLUMNS), .DEPTH(MATRIX_A_MEM_DEPTH)
  ) u_cnt_a (
    .clk(clk), .rst_n(rst_n), .clear(honour_start), .inc(inc_a),
    .address(addr_a), .row(row_a), .col(col_a),
    .last_col(last_col_a), .last_elem(last_elem_a)
  );

  matrix_addr_counter #(
    .ROWS(MATRIX_B_ROWS), .COLUMNS(MATRIX_B_COLUMNS), .DEPTH(MATRIX_B_MEM_DEPTH)
  ) u_cnt_b (
    .clk(clk), .rst_n(rst_n), .clear(honour_start), .inc(inc_b),
    .address(addr_b), .row(row_b), .col(col_b),
    .last_col(last_col_b), .last_elem(last_elem_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD_A;
      LOAD_A:  if (inc_a && last_elem_a) state_next = LOAD_B;
      LOAD_B:  if (inc_b && last_elem_b) state_next = FILLED;
      FILLED:  if (start) state_next = LOAD_A;
      default: state_next = IDLE;
    endcase
  end

  // Write port is registered one cycle behind acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_a      <= 1'b0;
      wr_address_a <= '0;
      wr_data_a    <= '0;
      new_row_a    <= 1'b0;
      wr_en_b      <= 1'b0;
      wr_address_b <= '0;
      wr_data_b    <= '0;
      new_row_b    <= 1'b0;
    end else begin
      wr_en_a   <= inc_a;
      new_row_a <= inc_a && last_col_a;
      wr_en_b   <= inc_b;
      new_row_b <= inc_b && last_col_b;
      if (inc_a) begin
        wr_address_a <= addr_a;
        wr_data_a    <= in_data;
      end
      if (inc_b) begin
        wr_address_b <= addr_b;
        wr_data_b    <= in_data;
      end
    end
  end

  // FILLED is entered with the final write in flight, so the flag lags one more cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      memory_filled <= 1'b0;
      load_error    <= 1'b0;
    end else begin
      memory_filled <= (state == FILLED) && !start;
      if (honour_start)
        load_error <= 1'b0;
      else if (accept && (in_last != final_b))
        load_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - scoreboard bench for matrix_loader (8x8 and 2x3/3x2 instances)
module tb_matrix_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int data;
    bit nr;
  } wr_t;

  wr_t qa1[$], qb1[$], qa2[$], qb2[$];

  // 8x8 instance
  logic        start1 = 0, in_valid1 = 0, in_last1 = 0;
  logic [31:0] in_data1 = 0;
  logic        in_ready1, wr_en_a1, wr_en_b1, new_row_a1, new_row_b1, filled1, err1;
  logic [5:0]  wr_address_a1, wr_address_b1;
  logic [31:0] wr_data_a1, wr_data_b1;

  // A 2x3, B 3x2, depth 8 instance
  logic        start2 = 0, in_valid2 = 0, in_last2 = 0;
  logic [31:0] in_data2 = 0;
  logic        in_ready2, wr_en_a2, wr_en_b2, new_row_a2, new_row_b2, filled2, err2;
  logic [2:0]  wr_address_a2, wr_address_b2;
  logic [31:0] wr_data_a2, wr_data_b2;

  matrix_loader dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_data(in_data1),
    .in_valid(in_valid1), .in_last(in_last1), .in_ready(in_ready1),
    .wr_en_a(wr_en_a1), .wr_address_a(wr_address_a1), .wr_data_a(wr_data_a1),
    .wr_en_b(wr_en_b1), .wr_address_b(wr_address_b1), .wr_data_b(wr_data_b1),
    .new_row_a(new_row_a1), .new_row_b(new_row_b1),
    .memory_filled(filled1), .load_error(err1)
  );

  matrix_loader #(
    .MATRIX_A_MEM_DEPTH(8), .MATRIX_A_ROWS(2), .MATRIX_A_COLUMNS(3),
    .MATRIX_B_MEM_DEPTH(8), .MATRIX_B_ROWS(3), .MATRIX_B_COLUMNS(2),
    .MATRIX_MEM_WIDTH(32)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_data(in_data2),
    .in_valid(in_valid2), .in_last(in_last2), .in_ready(in_ready2),
    .wr_en_a(wr_en_a2), .wr_address_a(wr_address_a2), .wr_data_a(wr_data_a2),
    .wr_en_b(wr_en_b2), .wr_address_b(wr_address_b2), .wr_data_b(wr_data_b2),
    .new_row_a(new_row_a2), .new_row_b(new_row_b2),
    .memory_filled(filled2), .load_error(err2)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic void cmp(string tag, wr_t e, int addr, int data, bit nr);
    check({tag, "_addr"}, 64'(addr), 64'(e.addr));
    check({tag, "_data"}, 64'(data), 64'(e.data));
    check({tag, "_new_row"}, 64'(nr), 64'(e.nr));
  endfunction

  // Monitor: every write strobe must match the head of its expected queue.
  always @(negedge clk) begin
    if (wr_en_a1) begin
      if (qa1.size() == 0) check("a1_unexpected_write", 1, 0);
      else cmp("a1", qa1.pop_front(), int'(wr_address_a1), int'(wr_data_a1), new_row_a1);
    end else if (new_row_a1) check("a1_stray_new_row", 1, 0);
    if (wr_en_b1) begin
      if (qb1.size() == 0) check("b1_unexpected_write", 1, 0);
      else cmp("b1", qb1.pop_front(), int'(wr_address_b1), int'(wr_data_b1), new_row_b1);
    end else if (new_row_b1) check("b1_stray_new_row", 1, 0);
    if (wr_en_a2) begin
      if (qa2.size() == 0) check("a2_unexpected_write", 1, 0);
      else cmp("a2", qa2.pop_front(), int'(wr_address_a2), int'(wr_data_a2), new_row_a2);
    end else if (new_row_a2) check("a2_stray_new_row", 1, 0);
    if (wr_en_b2) begin
      if (qb2.size() == 0) check("b2_unexpected_write", 1, 0);
      else cmp("b2", qb2.pop_front(), int'(wr_address_b2), int'(wr_data_b2), new_row_b2);
    end else if (new_row_b2) check("b2_stray_new_row", 1, 0);
  end

  function automatic bit rdy(int w);
    return (w == 0) ? in_ready1 : in_ready2;
  endfunction

  function automatic bit mf(int w);
    return (w == 0) ? filled1 : filled2;
  endfunction

  function automatic bit le(int w);
    return (w == 0) ? err1 : err2;
  endfunction

  task automatic set_start(int w, bit v);
    if (w == 0) start1 = v; else start2 = v;
  endtask

  task automatic drive(int w, bit v, int data, bit last);
    if (w == 0) begin in_valid1 = v; in_data1 = data; in_last1 = last; end
    else        begin in_valid2 = v; in_data2 = data; in_last2 = last; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int w);
    set_start(w, 1'b1);
    tick();
    set_start(w, 1'b0);
  endtask

  task automatic send_beat(int w, int data, bit last);
    bit got = 0;
    int waited = 0;
    drive(w, 1'b1, data, last);
    while (!got && waited < 50) begin
      @(negedge clk);
      if (rdy(w)) got = 1;
      tick();
      waited++;
    end
    if (!got) check("accept_timeout", 0, 1);
    drive(w, 1'b0, 0, 1'b0);
  endtask

  task automatic push_exp(int w, bit is_a, int addr, int data, bit nr);
    wr_t e;
    e.addr = addr; e.data = data; e.nr = nr;
    if (w == 0) begin if (is_a) qa1.push_back(e); else qb1.push_back(e); end
    else        begin if (is_a) qa2.push_back(e); else qb2.push_back(e); end
  endtask

  // Full A-then-B load; bad_idx flips in_last on that beat to force a framing error.
  task automatic stream(int w, int ra, int ca, int rb, int cb, int base_a, int base_b,
                        int gap, int bad_idx, bit start_mid_b);
    int na = ra * ca;
    int nb = rb * cb;
    for (int i = 0; i < na + nb; i++) begin
      bit last = (i == na + nb - 1);
      if (i == bad_idx) last = ~last;
      if (i < na) push_exp(w, 1'b1, i, base_a + i, (i % ca) == ca - 1);
      else        push_exp(w, 1'b0, i - na, base_b + i - na, ((i - na) % cb) == cb - 1);
      if (start_mid_b && i == na + 3) set_start(w, 1'b1);
      send_beat(w, (i < na) ? base_a + i : base_b + i - na, last);
      set_start(w, 1'b0);
      if (i == bad_idx) check("load_error_set", 64'(le(w)), 1);
      if (i != na + nb - 1)
        for (int g = 0; g < gap; g++) tick();
    end
    check("filled_not_yet", 64'(mf(w)), 0);
    tick();
    check("filled_after_two", 64'(mf(w)), 1);
    check("ready_low_filled", 64'(rdy(w)), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready1), 0);
    check("rst_wr_en_a", 64'(wr_en_a1), 0);
    check("rst_wr_en_b", 64'(wr_en_b1), 0);
    check("rst_filled", 64'(filled1), 0);
    check("rst_error", 64'(err1), 0);
    check("rst_addr_a", 64'(wr_address_a1), 0);
    rst_n = 1;
    tick();
    check("idle_in_ready", 64'(in_ready1), 0);

    // continuous 8x8 load
    do_start(0);
    check("load_a_ready", 64'(in_ready1), 1);
    stream(0, 8, 8, 8, 8, 0, 100, 0, -1, 0);
    check("clean_no_error", 64'(err1), 0);

    // restart from FILLED, every-third-cycle valid, stray start in LOAD_B
    do_start(0);
    check("restart_filled_drop", 64'(filled1), 0);
    check("restart_ready_rise", 64'(in_ready1), 1);
    stream(0, 8, 8, 8, 8, 0, 100, 2, -1, 1);
    check("gap_no_error", 64'(err1), 0);

    // early in_last on beat 10
    do_start(0);
    stream(0, 8, 8, 8, 8, 1000, 2000, 0, 9, 0);
    check("error_sticky", 64'(err1), 1);
    check("error_filled", 64'(filled1), 1);
    do_start(0);
    check("start_clears_error", 64'(err1), 0);
    check("start_clears_filled", 64'(filled1), 0);

    // reset at A beat 20, then restart from address 0
    for (int i = 0; i < 19; i++) begin
      push_exp(0, 1'b1, i, 300 + i, (i % 8) == 7);
      send_beat(0, 300 + i, 1'b0);
    end
    drive(0, 1'b1, 319, 1'b0);
    rst_n = 0;
    tick();
    drive(0, 1'b0, 0, 1'b0);
    check("midrst_in_ready", 64'(in_ready1), 0);
    check("midrst_wr_en_a", 64'(wr_en_a1), 0);
    check("midrst_addr_a", 64'(wr_address_a1), 0);
    check("midrst_data_a", 64'(wr_data_a1), 0);
    check("midrst_filled", 64'(filled1), 0);
    check("midrst_error", 64'(err1), 0);
    rst_n = 1;
    tick();
    do_start(0);
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 1'b1, i, 500 + i, 1'b0);
      send_beat(0, 500 + i, 1'b0);
    end
    tick();
    tick();

    // non-square small matrices
    do_start(1);
    stream(1, 2, 3, 3, 2, 10, 20, 0, -1, 0);
    check("small_no_error", 64'(err2), 0);
    tick();
    tick();

    check("a1_pending", 64'(qa1.size()), 0);
    check("b1_pending", 64'(qb1.size()), 0);
    check("a2_pending", 64'(qa2.size()), 0);
    check("b2_pending", 64'(qb2.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
